// File: rtl/stream_mux_rr_pkg.sv
// Shared constants for the stream_mux_rr slice: mode select encoding.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// in_data is packed so channel i occupies bits [i*WIDTH +: WIDTH].
interface stream_mux_rr_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N)
);
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [N-1:0]              in_valid;
    logic [N-1:0][WIDTH-1:0]   in_data;
    logic [N-1:0]              in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_ready;

    // Producer/consumer side (drives channel inputs, mode, and out_ready)
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    // Mux side
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: scans req starting at ptr, wrapping at N-1.
// ptr advances past the granted index only when en (a real transfer) is set.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);
    logic [SELW-1:0] ptr;

    // Priority scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1; first requester wins
    always_comb begin
        int              idx_i;
        logic [SELW-1:0] idx;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx_i     = 0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx_i = int'(ptr) + k;
            if (idx_i >= N) idx_i = idx_i - N;
            idx = SELW'(idx_i);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Pointer moves to the channel after the one just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (en)
            ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
    end
endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with fixed (sel) or round-robin selection and a
// single-entry registered output. Backpressure reaches in_ready in the same
// cycle; a drain and a new load may happen on the same edge.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    logic             load_en;
    logic             fix_vld;
    logic             rr_vld;
    logic [SELW-1:0]  rr_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic             xfer;
    logic             is_rr;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_chan_q;

    assign is_rr   = (bus.mode == MODE_RR);
    assign load_en = !out_valid_q || bus.out_ready;

    // Fixed path: sel beyond the last channel never grants
    assign fix_vld = (int'(bus.sel) < N) && bus.in_valid[bus.sel];

    assign grant_vld = is_rr ? rr_vld : fix_vld;
    assign grant_idx = is_rr ? rr_idx : bus.sel;

    // No transfer may complete while reset is asserted
    assign xfer = !rst && load_en && grant_vld;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (xfer && is_rr),
        .req       (bus.in_valid),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    // One-hot ready for the granted channel only
    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready = N'(1) << grant_idx;
    end

    // Output register: load on grant, empty when free with nothing granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[grant_idx];
                out_chan_q  <= grant_idx;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel and a 3-channel instance.
// Stimulus pushes hand-computed beats into per-DUT queues; a negedge monitor
// pops and compares every beat the consumer accepts.
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.N(4), .WIDTH(8)) b4 ();
    stream_mux_rr_if #(.N(3), .WIDTH(8)) b3 ();

    stream_mux_rr #(.WIDTH(8), .N(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    stream_mux_rr #(.WIDTH(8), .N(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
    } beat_t;

    beat_t q4[$];
    beat_t q3[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [1:0] c, input logic [7:0] d);
        beat_t b;
        b.chan = c; b.data = d;
        q4.push_back(b);
    endtask

    task automatic push3(input logic [1:0] c, input logic [7:0] d);
        beat_t b;
        b.chan = c; b.data = d;
        q3.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted output beat must match the queue head
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (b4.out_valid && b4.out_ready) begin
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL n4_unexpected_beat: got chan %0d data %0h expected none",
                             b4.out_chan, b4.out_data);
                end else begin
                    e = q4.pop_front();
                    chk("n4_beat", {22'd0, b4.out_chan, b4.out_data}, {22'd0, e.chan, e.data});
                end
            end
            if (b3.out_valid && b3.out_ready) begin
                if (q3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL n3_unexpected_beat: got chan %0d data %0h expected none",
                             b3.out_chan, b3.out_data);
                end else begin
                    e = q3.pop_front();
                    chk("n3_beat", {22'd0, b3.out_chan, b3.out_data}, {22'd0, e.chan, e.data});
                end
            end
        end
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b4.mode = 1'b1; b4.sel = '0; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        b4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b3.mode = 1'b1; b3.sel = '0; b3.in_valid = 3'b111;  b3.out_ready = 1'b1;
        b3.in_data = {8'hB2, 8'hB1, 8'hB0};
        repeat (2) step();
        #1;
        // Reset state; in_ready must stay low even with every channel valid
        chk("rst_out_valid", {31'd0, b4.out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, b4.out_data},  32'd0);
        chk("rst_out_chan",  {30'd0, b4.out_chan},  32'd0);
        chk("rst_in_ready",  {28'd0, b4.in_ready},  32'd0);
        chk("rst_in_ready3", {29'd0, b3.in_ready},  32'd0);
        b3.in_valid = 3'b000;

        // Fixed mode sel=2: only channel 2 ready every cycle
        b4.mode = 1'b0; b4.sel = 2'd2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fixed_in_ready", {28'd0, b4.in_ready}, 32'h4);
            push4(2'd2, 8'hA2);
            step();
        end

        // Round-robin from ptr 0 (fixed mode left ptr alone)
        b4.mode = 1'b1;
        #1;
        chk("rr_first_ready", {28'd0, b4.in_ready}, 32'h1);
        push4(2'd0, 8'hA0); push4(2'd1, 8'hA1); push4(2'd2, 8'hA2);
        push4(2'd3, 8'hA3); push4(2'd0, 8'hA0);
        repeat (6) step();
        // Sixth beat (chan 1) is held, then discarded by reset
        b4.out_ready = 1'b0; b4.in_valid = 4'b0000;
        #1;
        chk("held_valid", {31'd0, b4.out_valid}, 32'd1);
        chk("held_chan",  {30'd0, b4.out_chan},  32'd1);

        // Mid-stream reset clears the register asynchronously and ptr to 0
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, b4.out_valid}, 32'd0);
        chk("midrst_data",  {24'd0, b4.out_data},  32'd0);
        chk("midrst_chan",  {30'd0, b4.out_chan},  32'd0);
        b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", {28'd0, b4.in_ready}, 32'd0);
        step();
        chk("midrst_no_load", {31'd0, b4.out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", {28'd0, b4.in_ready}, 32'h1);

        // Round-robin over 4'b1010 from ptr 0: 1,3,1,3
        b4.in_valid = 4'b1010;
        #1;
        chk("rr1010_ready", {28'd0, b4.in_ready}, 32'h2);
        push4(2'd1, 8'hA1); push4(2'd3, 8'hA3); push4(2'd1, 8'hA1); push4(2'd3, 8'hA3);
        repeat (4) step();

        // Backpressure for 3 cycles holding the chan-3 beat
        b4.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_valid",    {31'd0, b4.out_valid}, 32'd1);
            chk("stall_data",     {24'd0, b4.out_data},  32'hA3);
            chk("stall_in_ready", {28'd0, b4.in_ready},  32'd0);
            step();
        end
        b4.out_ready = 1'b1;
        #1;
        // ptr was 0 before the stall, so channel 1 is next
        chk("unstall_grant", {28'd0, b4.in_ready}, 32'h2);
        push4(2'd1, 8'hA1);
        step();

        // Fixed mode sel=3 for two beats; ptr stays at 2
        b4.mode = 1'b0; b4.sel = 2'd3; b4.in_valid = 4'b1111;
        #1;
        chk("switch_fixed_ready", {28'd0, b4.in_ready}, 32'h8);
        push4(2'd3, 8'hA3); push4(2'd3, 8'hA3);
        repeat (2) step();
        b4.mode = 1'b1;
        #1;
        chk("switch_back_ready", {28'd0, b4.in_ready}, 32'h4);
        push4(2'd2, 8'hA2);
        step();
        b4.in_valid = 4'b0000;
        #1;
        chk("idle_in_ready", {28'd0, b4.in_ready}, 32'd0);
        step();
        // Empty load clears valid but keeps data/chan
        chk("drain_valid", {31'd0, b4.out_valid}, 32'd0);
        chk("drain_data",  {24'd0, b4.out_data},  32'hA2);
        chk("drain_chan",  {30'd0, b4.out_chan},  32'd2);

        // N=3: round-robin wraps after channel 2
        b3.mode = 1'b1; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
        #1;
        chk("n3_first_ready", {29'd0, b3.in_ready}, 32'h1);
        push3(2'd0, 8'hB0); push3(2'd1, 8'hB1); push3(2'd2, 8'hB2); push3(2'd0, 8'hB0);
        repeat (4) step();
        // sel=3 is beyond the last channel: no grant
        b3.mode = 1'b0; b3.sel = 2'd3;
        #1;
        chk("n3_sel3_ready", {29'd0, b3.in_ready}, 32'd0);
        step();
        chk("n3_sel3_valid", {31'd0, b3.out_valid}, 32'd0);
        chk("n3_sel3_chan",  {30'd0, b3.out_chan},  32'd0);

        repeat (2) step();
        chk("q4_drained", q4.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output and valid/ready handshaking on every port. It generalises the team's 4:1 single-bit gate-level multiplexer to arbitrary width and channel count. It adds a round-robin arbitration mode alongside externally selected fixed mode. It sits between several producers and one consumer, for example request merging ahead of a shared bus.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- N, 4, number of input channels (≥2, need not be a power of two)
- SELW, $clog2(N), width of channel index fields (derived; not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = fixed (channel given by sel), 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- in_valid  in  N  per-channel valid; bit i belongs to channel i
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel ready (combinational)
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered data
- out_chan  out  SELW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts the beat

## Operation
- Single-entry output register; load_en = !out_valid || out_ready.
- Grant (combinational, one-hot or none):
  - Fixed mode: grant channel sel iff sel < N and in_valid[sel]. If sel ≥ N, there is no grant.
  - Round-robin mode: among channels with in_valid set, grant the first index found scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[i] = load_en && grant == i. At most one in_ready bit is high per cycle. in_ready never depends on in_valid of other channels in fixed mode.
- Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge out_data ← channel i data, out_chan ← i, out_valid ← 1.
- When load_en is set and there is no grant, out_valid ← 0 on the edge. out_data and out_chan hold their previous values.
- When out_valid && !out_ready, the register holds and all in_ready are 0.
- Round-robin pointer ptr (SELW bits, range 0..N-1):
  - Updates only on a transfer, and only in mode 1: ptr ← (grant == N-1) ? 0 : grant+1.
  - ptr is not modified in fixed mode.
  - On return to mode 1, arbitration resumes from the retained ptr.
- mode and sel are sampled combinationally each cycle. A change affects only the grant of that cycle and never an already-registered beat.
- Producers must hold in_data stable while in_valid is high and in_ready is low. The block does not check this.

## Timing
- Reset values: out_valid 0, out_data 0, out_chan 0, ptr 0. in_ready is all 0 during reset.
- Asserting rst mid-operation discards any held beat immediately. No transfer completes on an edge where rst is high.
- Latency is one cycle from an input transfer to out_valid.
- Throughput is one beat per cycle when out_ready is held high.
- Simultaneous drain and load: a consumer take and a new input transfer on the same edge is a legal full-rate case. The new beat replaces the old one.
- Backpressure propagates to in_ready in the same cycle (combinational path out_ready → in_ready).

## Structure
- No shared package is needed. WIDTH, N and SELW are module parameters.
- The mode encoding constants (MODE_FIXED = 0, MODE_RR = 1) go in the team's common defines package.
- One natural sub-module is rr_arbiter #(N), containing the pointer-based priority scan and the ptr register. Its ports are clk, rst, en, req[N], grant_idx, grant_vld.
- The top level holds the fixed-mode path, the output register and the handshake logic.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 → out_valid, out_data, out_chan go to 0 immediately; after release, with mode=1 and all channels valid, the first grant is channel 0.
- Fixed mode, N=4, WIDTH=8: sel=2, in_valid=4'b1111, data 8'hA0..8'hA3, out_ready=1 → one cycle later out_data=8'hA2, out_chan=2, and in_ready=4'b0100 every cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 → out_chan sequence 0,1,2,3,0,1; with in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: out_ready=0 with out_valid=1 for 3 cycles → out_data stable, in_ready=0, ptr unchanged; on out_ready=1, the next grant follows the pre-stall ptr.
- Non-power-of-two N=3: mode=1, all valid → out_chan 0,1,2,0 (wraps at 2). Fixed mode with sel=3 → in_ready=0 and out_valid falls to 0.
- Mode switch: in mode 1 after granting channel 1, switch to mode 0 with sel=3 for two beats, then back to mode 1 → the next round-robin grant is channel 2.
